// File: rtl/reg_pipe_vr_pkg.sv
// +------------------------------------------------------------------+
// | reg_pipe_vr_pkg : shared helpers and defaults for reg_pipe_vr    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

`ifndef LOG2CEIL
`define LOG2CEIL(x) ($clog2(x))
`endif

package reg_pipe_vr_pkg;

  localparam int unsigned DEFAULT_RESET_VAL = 0;
  localparam string       CHK_PREFIX        = "reg_pipe_vr: ";

  // {in_xfer, out_xfer} as seen by the occupancy counter
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_OUT  = 2'b01,
    XFER_IN   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage

`default_nettype wire

// File: rtl/reg_pipe_stage.sv
// +------------------------------------------------------------------+
// | reg_pipe_stage : one valid/data slot of the reg_pipe_vr pipeline |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module reg_pipe_stage #(
  parameter int unsigned       DW        = 1,
  parameter logic [DW-1:0]     RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          up_vld,
  input  logic [DW-1:0] up_dat,
  input  logic          dn_rdy,
  output logic          rdy,
  output logic          vld,
  output logic [DW-1:0] dat
);

  assign rdy = ~vld | dn_rdy;

  // Data only moves with a valid word so bubbles never toggle the register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= 1'b0;
      dat <= RESET_VAL;
    end else if (rdy) begin
      vld <= up_vld;
      if (up_vld) begin
        dat <= up_dat;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xchecker_reg.sv
// +------------------------------------------------------------------+
// | xchecker_reg : flags X/Z on a control input (REG_PIPE_XCHECK_EN) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

`ifdef REG_PIPE_XCHECK_EN
module xchecker_reg
  import reg_pipe_vr_pkg::*;
#(
  parameter int unsigned DW          = 1,
  parameter              SIGNAL_NAME = "sig"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sig
);

  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(sig)) else $error("%s%s is unknown", CHK_PREFIX, SIGNAL_NAME);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/reg_pipe_vr.sv
// +------------------------------------------------------------------+
// | reg_pipe_vr : DEPTH-stage valid/ready pipeline register, DW wide |
// | Optional checkers: define REG_PIPE_XCHECK_EN.  Rev 1.0           |
// +------------------------------------------------------------------+
`default_nettype none

module reg_pipe_vr
  import reg_pipe_vr_pkg::*;
#(
  parameter int unsigned   DW        = 1,
  parameter int unsigned   DEPTH     = 2,
  parameter logic [DW-1:0] RESET_VAL = DW'(DEFAULT_RESET_VAL),
  parameter                REG_NAME  = "reg_pipe"
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DW-1:0]                    in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DW-1:0]                    out_data,
  output logic [`LOG2CEIL(DEPTH+1)-1:0]    level
);

  localparam int unsigned LW = `LOG2CEIL(DEPTH+1);

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_dn_rdy;
  logic [DW-1:0]    w_dat [DEPTH];
  logic             w_chain;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_rdy_unused;
  xfer_e            w_xfer;
  logic [LW-1:0]    r_level;

  // Ready seen by each stage, built from the valid flags alone so the chain has no loop
  always_comb begin
    w_chain  = out_ready;
    w_dn_rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_dn_rdy[i] = w_chain;
      w_chain     = w_chain | ~w_vld[i];
    end
  end

  assign in_ready     = w_rdy[0] & ~flush & ~rst;
  assign w_in_xfer    = in_valid & in_ready;
  assign w_out_xfer   = out_valid & out_ready & ~flush;
  assign w_rdy_unused = ^w_rdy;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic          w_up_vld;
    logic [DW-1:0] w_up_dat;

    if (i == 0) begin : g_head
      assign w_up_vld = w_in_xfer;
      assign w_up_dat = in_data;
    end else begin : g_body
      assign w_up_vld = w_vld[i-1];
      assign w_up_dat = w_dat[i-1];
    end

    reg_pipe_stage #(
      .DW        (DW),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .up_vld (w_up_vld),
      .up_dat (w_up_dat),
      .dn_rdy (w_dn_rdy[i]),
      .rdy    (w_rdy[i]),
      .vld    (w_vld[i]),
      .dat    (w_dat[i])
    );
  end

  assign out_valid = w_vld[DEPTH-1];
  assign out_data  = w_dat[DEPTH-1];
  assign level     = r_level;

  assign w_xfer = xfer_e'({w_in_xfer, w_out_xfer});

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_level <= '0;
    end else begin
      case (w_xfer)
        XFER_IN:  r_level <= r_level + LW'(1);
        XFER_OUT: r_level <= r_level - LW'(1);
        default:  r_level <= r_level;
      endcase
    end
  end

`ifdef REG_PIPE_XCHECK_EN
  logic          r_stall;
  logic [DW-1:0] r_held;

  xchecker_reg #(.DW(1), .SIGNAL_NAME({"in_valid of ", REG_NAME})) u_xchk_in_valid (
    .clk (clk), .rst (rst), .sig (in_valid)
  );
  xchecker_reg #(.DW(1), .SIGNAL_NAME({"out_ready of ", REG_NAME})) u_xchk_out_ready (
    .clk (clk), .rst (rst), .sig (out_ready)
  );
  xchecker_reg #(.DW(1), .SIGNAL_NAME({"flush of ", REG_NAME})) u_xchk_flush (
    .clk (clk), .rst (rst), .sig (flush)
  );

  always_ff @(posedge clk) begin
    r_stall <= in_valid & ~in_ready & ~rst & ~flush;
    r_held  <= in_data;
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (int'(r_level) <= int'(DEPTH)) else $error("%s%s level overflow", CHK_PREFIX, REG_NAME);
      if (r_stall && in_valid && !flush) begin
        assert (in_data == r_held) else $error("%s%s in_data changed while stalled", CHK_PREFIX, REG_NAME);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_pipe_vr.sv
// +------------------------------------------------------------------+
// | tb_reg_pipe_vr : directed self-checking bench for reg_pipe_vr    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_reg_pipe_vr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DW=8, DEPTH=3
  logic       a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_level;

  // DUT B: DW=16, DEPTH=1
  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [0:0]  b_level;

  int total = 0;
  int bad   = 0;

  reg_pipe_vr #(.DW(8), .DEPTH(3), .RESET_VAL(8'hEE), .REG_NAME("pipe_a")) u_dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .level     (a_level)
  );

  reg_pipe_vr #(.DW(16), .DEPTH(1), .RESET_VAL(16'hBEEF), .REG_NAME("pipe_b")) u_dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .level     (b_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("a_rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("a_rst_level", 32'(a_level), 32'd0);
    chk("a_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("a_rst_out_data", 32'(a_out_data), 32'hEE);
    chk("b_rst_out_data", 32'(b_out_data), 32'hBEEF);
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;
    chk("a_ready_after_rst", 32'(a_in_ready), 32'd1);

    // Unstalled stream 0x01..0x10: word j+1 accepted at edge j reaches the output after edge j+2
    for (int j = 0; j < 16; j++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(j + 1);
      #1;
      chk("stream_in_ready", 32'(a_in_ready), 32'd1);
      tick();
      chk("stream_level", 32'(a_level), (j < 2) ? 32'(j + 1) : 32'd3);
      chk("stream_out_valid", 32'(a_out_valid), (j >= 2) ? 32'd1 : 32'd0);
      if (j >= 2) chk("stream_out_data", 32'(a_out_data), 32'(j - 1));
    end
    a_in_valid = 1'b0;
    tick();
    chk("drain1_data", 32'(a_out_data), 32'h0F);
    chk("drain1_level", 32'(a_level), 32'd2);
    tick();
    chk("drain2_data", 32'(a_out_data), 32'h10);
    chk("drain2_level", 32'(a_level), 32'd1);
    tick();
    chk("drain3_valid", 32'(a_out_valid), 32'd0);
    chk("drain3_level", 32'(a_level), 32'd0);
    chk("empty_holds_data", 32'(a_out_data), 32'h10);

    // Fill to full with a stalled consumer, then drain
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data = 8'hA1; tick();
    a_in_data = 8'hA2; tick();
    a_in_data = 8'hA3; tick();
    a_in_data = 8'hFF;
    #1;
    chk("full_level", 32'(a_level), 32'd3);
    chk("full_in_ready", 32'(a_in_ready), 32'd0);
    chk("full_out_data", 32'(a_out_data), 32'hA1);
    tick();
    chk("full_hold_level", 32'(a_level), 32'd3);
    chk("full_hold_data", 32'(a_out_data), 32'hA1);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("fill_drain_a2", 32'(a_out_data), 32'hA2);
    chk("fill_drain_lvl2", 32'(a_level), 32'd2);
    tick();
    chk("fill_drain_a3", 32'(a_out_data), 32'hA3);
    chk("fill_drain_lvl1", 32'(a_level), 32'd1);
    tick();
    chk("fill_drain_valid", 32'(a_out_valid), 32'd0);
    chk("fill_drain_lvl0", 32'(a_level), 32'd0);

    // Full with simultaneous in and out transfer
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data = 8'hB1; tick();
    a_in_data = 8'hB2; tick();
    a_in_data = 8'hB3; tick();
    a_out_ready = 1'b1;
    a_in_data   = 8'hB4;
    #1;
    chk("both_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("both_level", 32'(a_level), 32'd3);
    chk("both_out_data", 32'(a_out_data), 32'hB2);
    a_in_valid = 1'b0;
    tick();
    chk("both_drain_b3", 32'(a_out_data), 32'hB3);
    tick();
    chk("both_drain_b4", 32'(a_out_data), 32'hB4);
    tick();
    chk("both_drain_lvl0", 32'(a_level), 32'd0);

    // Stalled tail with one word, two more collapse the bubbles
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'hC1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    chk("bubble_tail_valid", 32'(a_out_valid), 32'd1);
    chk("bubble_tail_level", 32'(a_level), 32'd1);
    a_in_valid = 1'b1;
    a_in_data  = 8'hC2;
    tick();
    chk("bubble_level2", 32'(a_level), 32'd2);
    a_in_data = 8'hC3;
    tick();
    chk("bubble_level3", 32'(a_level), 32'd3);
    chk("bubble_head_data", 32'(a_out_data), 32'hC1);
    a_in_valid = 1'b0;
    #1;
    chk("bubble_full_ready", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    tick();
    chk("bubble_order_c2", 32'(a_out_data), 32'hC2);
    tick();
    chk("bubble_order_c3", 32'(a_out_data), 32'hC3);
    tick();
    chk("bubble_empty", 32'(a_out_valid), 32'd0);

    // Flush with two words in flight and an offered input
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data = 8'hD1; tick();
    a_in_data = 8'hD2; tick();
    chk("flush_pre_level", 32'(a_level), 32'd2);
    a_flush   = 1'b1;
    a_in_data = 8'hD3;
    #1;
    chk("flush_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    chk("flush_level", 32'(a_level), 32'd0);
    chk("flush_out_valid", 32'(a_out_valid), 32'd0);
    chk("flush_out_data", 32'(a_out_data), 32'hEE);
    a_out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("flush_dropped_valid", 32'(a_out_valid), 32'd0);
    chk("flush_dropped_level", 32'(a_level), 32'd0);

    // DEPTH=1, DW=16: streaming then reset mid-stream
    b_in_valid = 1'b1;
    b_in_data  = 16'h1234;
    tick();
    chk("b_first_data", 32'(b_out_data), 32'h1234);
    chk("b_first_level", 32'(b_level), 32'd1);
    b_in_data = 16'h5678;
    #1;
    chk("b_full_pass_ready", 32'(b_in_ready), 32'd1);
    tick();
    chk("b_second_data", 32'(b_out_data), 32'h5678);
    chk("b_second_level", 32'(b_level), 32'd1);
    b_rst     = 1'b1;
    b_in_data = 16'h9999;
    #1;
    chk("b_rst_in_ready", 32'(b_in_ready), 32'd0);
    tick();
    chk("b_rst_out_valid", 32'(b_out_valid), 32'd0);
    chk("b_rst_data", 32'(b_out_data), 32'hBEEF);
    chk("b_rst_level", 32'(b_level), 32'd0);
    b_rst      = 1'b0;
    b_in_valid = 1'b0;
    #1;
    chk("b_ready_after_rst", 32'(b_in_ready), 32'd1);
    tick();
    chk("b_rst_dropped", 32'(b_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
